// File: rtl/riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_multicycle_ctrl
// Main control FSM of the multicycle RV32I core (lw, sw, R-type, I-type ALU,
// beq, jal). Sequences the shared ALU, the shared memory port and the
// instruction/data registers through Fetch/Decode/Execute/Writeback.
//
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   op, funct3, funct7b5   instruction fields from the instruction register
//   zero                   ALU zero flag (current cycle)
//   mem_ready              memory port completes its access this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write   datapath enables/selects
//   result_src, alu_src_a, alu_src_b, imm_src            datapath muxes
//   alu_control            ALU operation from the embedded ALU decoder
//   retire                 one-cycle pulse when an instruction completes
//   illegal                one-cycle pulse while in TRAP
//   state_dbg              current state code
// -----------------------------------------------------------------------------
module riscv_multicycle_ctrl #(
   parameter int              ST_W        = 4,
   parameter logic [ST_W-1:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic [2:0] alu_control,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state_dbg
);

   localparam logic [ST_W-1:0] S_FETCH    = 4'd0;
   localparam logic [ST_W-1:0] S_DECODE   = 4'd1;
   localparam logic [ST_W-1:0] S_MEMADR   = 4'd2;
   localparam logic [ST_W-1:0] S_MEMREAD  = 4'd3;
   localparam logic [ST_W-1:0] S_MEMWB    = 4'd4;
   localparam logic [ST_W-1:0] S_MEMWRITE = 4'd5;
   localparam logic [ST_W-1:0] S_EXECUTER = 4'd6;
   localparam logic [ST_W-1:0] S_EXECUTEI = 4'd7;
   localparam logic [ST_W-1:0] S_ALUWB    = 4'd8;
   localparam logic [ST_W-1:0] S_BEQ      = 4'd9;
   localparam logic [ST_W-1:0] S_JAL      = 4'd10;
   localparam logic [ST_W-1:0] S_TRAP     = 4'd11;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   logic [ST_W-1:0] state_q;
   logic [ST_W-1:0] state_d;
   logic [ST_W-1:0] state_nxt_s;
   logic            run_q;

   logic       pc_update_s;
   logic       branch_s;
   logic       ir_write_s;
   logic       reg_write_s;
   logic       mem_write_s;
   logic       retire_s;
   logic       illegal_s;
   logic [1:0] alu_op_s;

   // Run flop: held low through reset and the first edge after release so
   // that no write enable fires before the FSM has seen a clean FETCH.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the FSM is parked in FETCH until run is up.
   always_comb begin
      state_nxt_s = S_FETCH;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_nxt_s = S_DECODE;
            else           state_nxt_s = S_FETCH;
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt_s = S_MEMADR;
               OP_R:         state_nxt_s = S_EXECUTER;
               OP_I:         state_nxt_s = S_EXECUTEI;
               OP_BEQ:       state_nxt_s = S_BEQ;
               OP_JAL:       state_nxt_s = S_JAL;
               default:      state_nxt_s = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) state_nxt_s = S_MEMREAD;
            else             state_nxt_s = S_MEMWRITE;
         end
         S_MEMREAD: begin
            if (mem_ready) state_nxt_s = S_MEMWB;
            else           state_nxt_s = S_MEMREAD;
         end
         S_MEMWRITE: begin
            if (mem_ready) state_nxt_s = S_FETCH;
            else           state_nxt_s = S_MEMWRITE;
         end
         S_EXECUTER: state_nxt_s = S_ALUWB;
         S_EXECUTEI: state_nxt_s = S_ALUWB;
         S_JAL:      state_nxt_s = S_ALUWB;
         S_MEMWB:    state_nxt_s = S_FETCH;
         S_ALUWB:    state_nxt_s = S_FETCH;
         S_BEQ:      state_nxt_s = S_FETCH;
         S_TRAP:     state_nxt_s = S_FETCH;
         default:    state_nxt_s = S_FETCH;
      endcase
      if (run_q) state_d = state_nxt_s;
      else       state_d = S_FETCH;
   end

   // Moore output decode from the current state.
   always_comb begin
      pc_update_s = 1'b0;
      branch_s    = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      mem_write_s = 1'b0;
      retire_s    = 1'b0;
      illegal_s   = 1'b0;
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op_s    = 2'b00;
      case (state_q)
         S_FETCH: begin
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            ir_write_s  = mem_ready;
            pc_update_s = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_s = 1'b1;
            retire_s    = mem_ready;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op_s  = 2'b10;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op_s  = 2'b10;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op_s  = 2'b01;
            branch_s  = 1'b1;
            retire_s  = 1'b1;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            pc_update_s = 1'b1;
         end
         S_TRAP: begin
            illegal_s = 1'b1;
         end
         default: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
      endcase
   end

   // Immediate format depends only on the opcode, so it is valid in DECODE
   // for the branch-target computation.
   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   assign pc_write  = run_q & (pc_update_s | (branch_s & zero));
   assign ir_write  = run_q & ir_write_s;
   assign reg_write = run_q & reg_write_s;
   assign mem_write = run_q & mem_write_s;
   assign retire    = run_q & retire_s;
   assign illegal   = run_q & illegal_s;
   assign state_dbg = state_q;

   aludec u_aludec (
      .opb5        (op[5]),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_op      (alu_op_s),
      .alu_control (alu_control)
   );

endmodule

// -----------------------------------------------------------------------------
// aludec: ALU decoder. alu_op 00 add, 01 sub, 10 decode from funct3/funct7.
// Ports: opb5, funct3, funct7b5, alu_op in; alu_control out.
// -----------------------------------------------------------------------------
module aludec (
   input  logic       opb5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] alu_op,
   output logic [2:0] alu_control
);

   // funct7b5 only selects sub for R-type; I-type addi keeps add.
   always_comb begin
      case (alu_op)
         2'b00: alu_control = 3'b000;
         2'b01: alu_control = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000: begin
                  if (opb5 & funct7b5) alu_control = 3'b001;
                  else                 alu_control = 3'b000;
               end
               3'b010:  alu_control = 3'b101;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'bxxx;
            endcase
         end
         default: alu_control = 3'bxxx;
      endcase
   end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
module tb_riscv_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   int st_q[$];
   bit rd_q[$];

   riscv_multicycle_ctrl dut (
      .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .reg_write(reg_write), .alu_control(alu_control), .retire(retire),
      .illegal(illegal), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs of one cycle, taken from the per-state output table.
   task automatic check_cycle(input int s, input bit r, input bit z,
                              input logic [6:0] o, input logic [2:0] f3, input bit f7);
      logic e_pc = 0, e_ir = 0, e_rw = 0, e_mw = 0, e_ret = 0, e_ill = 0, e_adr = 0;
      logic [1:0] e_rs = 0, e_a = 0, e_b = 0, e_imm = 0;
      logic [2:0] e_alu = 3'b000;
      case (s)
         0:  begin e_b = 2; e_rs = 2; e_ir = r; e_pc = r; end
         1:  begin e_a = 1; e_b = 1; end
         2:  begin e_a = 2; e_b = 1; end
         3:  e_adr = 1;
         4:  begin e_rs = 1; e_rw = 1; e_ret = 1; end
         5:  begin e_adr = 1; e_mw = 1; e_ret = r; end
         6:  e_a = 2;
         7:  begin e_a = 2; e_b = 1; end
         8:  begin e_rw = 1; e_ret = 1; end
         9:  begin e_a = 2; e_ret = 1; e_pc = z; e_alu = 3'b001; end
         10: begin e_a = 1; e_b = 2; e_pc = 1; end
         11: e_ill = 1;
         default: ;
      endcase
      if (s == 6 || s == 7) begin
         case (f3)
            3'b000:  e_alu = (s == 6 && f7) ? 3'b001 : 3'b000;
            3'b010:  e_alu = 3'b101;
            3'b110:  e_alu = 3'b011;
            default: e_alu = 3'b010;
         endcase
      end
      if (o == 7'b0100011) e_imm = 1;
      else if (o == 7'b1100011) e_imm = 2;
      else if (o == 7'b1101111) e_imm = 3;
      check_eq("state_dbg", state_dbg, s[3:0]);
      check_eq("pc_write", pc_write, e_pc);
      check_eq("ir_write", ir_write, e_ir);
      check_eq("reg_write", reg_write, e_rw);
      check_eq("mem_write", mem_write, e_mw);
      check_eq("retire", retire, e_ret);
      check_eq("illegal", illegal, e_ill);
      check_eq("adr_src", adr_src, e_adr);
      check_eq("result_src", result_src, e_rs);
      check_eq("alu_src_a", alu_src_a, e_a);
      check_eq("alu_src_b", alu_src_b, e_b);
      check_eq("imm_src", imm_src, e_imm);
      check_eq("alu_control", alu_control, e_alu);
   endtask

   task automatic push(input int s, input bit r);
      st_q.push_back(s);
      rd_q.push_back(r);
   endtask

   // Assert reset for one cycle and release it; run stays low one more cycle.
   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      mem_ready = 1'b1;
      #1;
      check_eq("rst_state", state_dbg, 8'd0);
      check_eq("rst_reg_write", reg_write, 8'd0);
      check_eq("rst_ir_write", ir_write, 8'd0);
      check_eq("rst_pc_write", pc_write, 8'd0);
      check_eq("rst_mem_write", mem_write, 8'd0);
      check_eq("rst_retire", retire, 8'd0);
      @(negedge clk);
      check_eq("rst_hold_state", state_dbg, 8'd0);
      resetn = 1'b1;
      #1;
      check_eq("run0_state", state_dbg, 8'd0);
      check_eq("run0_ir_write", ir_write, 8'd0);
      check_eq("run0_pc_write", pc_write, 8'd0);
      check_eq("run0_reg_write", reg_write, 8'd0);
      check_eq("run0_alu_src_b", alu_src_b, 8'd2);
   endtask

   // Build the expected state trace of one instruction from its opcode and
   // the number of memory wait cycles, then play it cycle by cycle.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                            input bit z, input int wf, input int wm, input bit abort);
      st_q.delete();
      rd_q.delete();
      repeat (wf) push(0, 1'b0);
      push(0, 1'b1);
      push(1, 1'($urandom_range(0, 1)));
      case (o)
         7'b0000011: begin
            push(2, 1'($urandom_range(0, 1)));
            repeat (wm) push(3, 1'b0);
            push(3, 1'b1);
            push(4, 1'($urandom_range(0, 1)));
         end
         7'b0100011: begin
            push(2, 1'($urandom_range(0, 1)));
            repeat (wm) push(5, 1'b0);
            push(5, 1'b1);
         end
         7'b0110011: begin push(6, 1'($urandom_range(0, 1))); push(8, 1'($urandom_range(0, 1))); end
         7'b0010011: begin push(7, 1'($urandom_range(0, 1))); push(8, 1'($urandom_range(0, 1))); end
         7'b1100011: push(9, 1'($urandom_range(0, 1)));
         7'b1101111: begin push(10, 1'($urandom_range(0, 1))); push(8, 1'($urandom_range(0, 1))); end
         default:    push(11, 1'($urandom_range(0, 1)));
      endcase
      for (int k = 0; k < st_q.size(); k++) begin
         @(negedge clk);
         op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rd_q[k];
         #1;
         check_cycle(st_q[k], rd_q[k], z, o, f3, f7);
         if (abort && st_q[k] == 6) begin
            do_reset();
            return;
         end
      end
   endtask

   function automatic logic [2:0] rand_f3();
      case ($urandom_range(0, 3))
         0: return 3'b000;
         1: return 3'b010;
         2: return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   initial begin
      logic [6:0] o;
      do_reset();
      // Directed cases
      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0); // add
      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0); // sub
      run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0); // addi, f7b5 set
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0); // lw, 3 waits
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0); // beq taken
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0); // beq not taken
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2, 1'b0); // sw, 2 waits
      run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0); // jal
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0); // illegal
      run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 1, 0, 1'b1); // reset during EXECUTER
      run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0);
      // Randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 6))
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1100011;
            5: o = 7'b1101111;
            default: begin
               o = 7'($urandom_range(0, 127));
               if (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                   o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111)
                  o = 7'b1111111;
            end
         endcase
         run_instr(o, rand_f3(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 3),
                   (o == 7'b0110011) && ($urandom_range(0, 15) == 0));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). It sequences one shared ALU, one shared memory port and the instruction/data registers across Fetch/Decode/Execute/Writeback. It drives ALUOp into an internally instantiated aludec, whose ALUControl it exports. It adds a memory-ready handshake, a retire pulse and an illegal-opcode trap.

Parameters:
ST_W, 4, state register width
RESET_STATE, 4'd0, state entered on reset (FETCH)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag (combinational, current cycle)
mem_ready  input  1  memory port completes access this cycle
pc_write  output  1  PC register enable
adr_src  output  1  0=PC, 1=ALUOut as memory address
mem_write  output  1  memory write strobe
ir_write  output  1  instruction/OldPC register enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4
imm_src  output  2  00 I, 01 S, 10 B, 11 J
reg_write  output  1  register file write enable
alu_control  output  3  from aludec (000 add, 001 sub, 010 and, 011 or, 101 slt)
retire  output  1  one-cycle pulse on instruction completion
illegal  output  1  one-cycle pulse in TRAP
state_dbg  output  4  current state

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11. Codes 12-15 go to FETCH on the next clock.
- Reset: resetn low drives state to FETCH asynchronously. A run flop clears to 0 asynchronously and sets to 1 on the first clk after resetn deasserts.
- While run=0: pc_write, ir_write, reg_write, mem_write, retire and illegal are forced to 0; the other outputs show FETCH values.
- Outputs are Moore, decoded from state. Two exceptions: pc_write = pc_update | (branch & zero), and imm_src is decoded from op alone (lw/I-type 00, sw 01, beq 10, jal 11, others 00).
- Unlisted outputs below are 0; alu_op = 00.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10. ir_write and pc_update are asserted only when mem_ready=1. Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01 (computes branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01. Goes to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Waits for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Next FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1 held until mem_ready. retire=mem_ready. Goes to FETCH when mem_ready.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Next FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, retire=1. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1. Next ALUWB.
- TRAP: illegal=1, no writes. Next FETCH (instruction skipped; PC already advanced).
- aludec is instantiated with opb5=op[5], funct3, funct7b5, alu_op. alu_control is passed through combinationally. Unsupported funct3 gives xxx and must only occur in EXECUTER/EXECUTEI.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction aborts it: no further write enables until run=1 again in FETCH.
- Cycle counts with mem_ready tied to 1: lw 5; sw, R-type, I-type, jal 4; beq 3.

Test Plan:
- Reset, then release with mem_ready=1: cycle 0 after release has all write enables 0 and state_dbg=0. Next cycle ir_write=1, pc_write=1, alu_src_b=10.
- add (op=0110011, funct3=000, funct7b5=0): states 0,1,6,8,0. alu_control=000 in state 6. reg_write=1 and retire=1 only in state 8.
- sub (funct7b5=1) -> alu_control=001. addi with funct7b5=1 (op=0010011) -> alu_control=000. lw with mem_ready low 3 cycles in MEMREAD -> stays in state 3 for 4 cycles, then 4, then retire.
- beq with zero=1 -> pc_write=1 in state 9. With zero=0 -> pc_write=0. Both give 3 cycles, imm_src=10, retire=1.
- sw with mem_ready low 2 cycles -> mem_write=1 for 3 consecutive cycles, retire only on the last. jal -> states 0,1,10,8, imm_src=11, pc_write=1 in state 10.
- op=1111111 -> TRAP with illegal=1 for one cycle, no reg_write/mem_write. resetn pulsed low during EXECUTER -> immediate FETCH, no ALUWB write.
